// File: rtl/mem_mp_pkg.sv
// Shared types, limits and width helpers for the multi-port memory.
package mem_mp_pkg;

   typedef enum logic {CLEAR, READY} mem_state_t;

   localparam int MAX_RD_PORTS = 4;

   function automatic int calc_addr_w(input int mem_size);
      return (mem_size > 1) ? $clog2(mem_size) : 1;
   endfunction

   function automatic int calc_be_w(input int data_w);
      return data_w / 8;
   endfunction

endpackage

// File: rtl/mem_mp_if.sv
// Bus bundle for mem_mp: one byte-enabled write port, NUM_RD packed read ports, status.
interface mem_mp_if #(
   parameter int DATA_W   = 16,
   parameter int MEM_SIZE = 1000,
   parameter int NUM_RD   = 2
);
   localparam int ADDR_W = mem_mp_pkg::calc_addr_w(MEM_SIZE);
   localparam int BE_W   = mem_mp_pkg::calc_be_w(DATA_W);

   logic                     write;
   logic [ADDR_W-1:0]        addr_w;
   logic [DATA_W-1:0]        data_in;
   logic [BE_W-1:0]          be_w;
   logic [NUM_RD-1:0]        read;
   logic [NUM_RD*ADDR_W-1:0] addr_r;
   logic [NUM_RD*DATA_W-1:0] data_out;
   logic [NUM_RD-1:0]        rd_valid;
   logic                     busy;
   logic                     err_addr;

   modport master (
      output write, addr_w, data_in, be_w, read, addr_r,
      input  data_out, rd_valid, busy, err_addr
   );

   modport slave (
      input  write, addr_w, data_in, be_w, read, addr_r,
      output data_out, rd_valid, busy, err_addr
   );

endinterface

// File: rtl/mem_mp_rd_pipe.sv
// One read port: range check, optional same-cycle write forwarding (MEM_FWD_EN),
// and the 1- or 2-cycle data/valid delay. The array read register lives in the top.
module mem_mp_rd_pipe
   import mem_mp_pkg::*;
#(
   parameter int DATA_W   = 16,
   parameter int MEM_SIZE = 1000,
   parameter int RD_LAT   = 1
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic                                  accept_i,
   input  logic                                  read_i,
   input  logic [calc_addr_w(MEM_SIZE)-1:0]      addr_i,
   input  logic                                  wr_en_i,
   input  logic [calc_addr_w(MEM_SIZE)-1:0]      wr_addr_i,
   input  logic [DATA_W-1:0]                     wr_data_i,
   input  logic [calc_be_w(DATA_W)-1:0]          wr_be_i,
   input  logic [DATA_W-1:0]                     raw_i,
   output logic                                  rd_en_o,
   output logic [calc_addr_w(MEM_SIZE)-1:0]      rd_addr_o,
   output logic                                  oor_o,
   output logic [DATA_W-1:0]                     data_o,
   output logic                                  valid_o
);
   localparam int ADDR_W = calc_addr_w(MEM_SIZE);

   logic              req;
   logic              in_range;
   logic              v1_q;
   logic              zero1_q;
   logic [DATA_W-1:0] word1;

   assign req       = accept_i & read_i;
   assign in_range  = ({1'b0, addr_i} < (ADDR_W+1)'(MEM_SIZE));
   assign rd_en_o   = req & in_range;
   assign rd_addr_o = addr_i;
   assign oor_o     = req & ~in_range;

   // zero1_q masks the raw word: out-of-range reads and the post-reset output read as 0
   always_ff @(posedge clk) begin
      if (!rst) begin
         v1_q    <= 1'b0;
         zero1_q <= 1'b1;
      end else begin
         v1_q <= req;
         if (req) begin
            zero1_q <= ~in_range;
         end
      end
   end

`ifdef MEM_FWD_EN
   logic                 fwd1_q;
   logic [DATA_W-1:0]    wdat1_q;
   logic [DATA_W/8-1:0]  wbe1_q;
   logic [DATA_W-1:0]    merged;

   always_ff @(posedge clk) begin
      if (!rst) begin
         fwd1_q <= 1'b0;
      end else if (req) begin
         fwd1_q <= in_range && wr_en_i && (wr_addr_i == addr_i);
      end
   end

   always_ff @(posedge clk) begin
      if (req) begin
         wdat1_q <= wr_data_i;
         wbe1_q  <= wr_be_i;
      end
   end

   for (genvar gi = 0; gi < DATA_W/8; gi++) begin : g_merge
      assign merged[gi*8 +: 8] = (fwd1_q && wbe1_q[gi]) ? wdat1_q[gi*8 +: 8] : raw_i[gi*8 +: 8];
   end

   assign word1 = zero1_q ? '0 : merged;
`else
   logic unused_wr;
   assign unused_wr = ^{wr_en_i, wr_addr_i, wr_data_i, wr_be_i};
   assign word1     = zero1_q ? '0 : raw_i;
`endif

   if (RD_LAT == 2) begin : g_lat2
      logic [DATA_W-1:0] out_q;
      logic              v2_q;

      always_ff @(posedge clk) begin
         if (!rst) begin
            out_q <= '0;
            v2_q  <= 1'b0;
         end else begin
            v2_q <= v1_q;
            if (v1_q) begin
               out_q <= word1;
            end
         end
      end

      assign data_o  = out_q;
      assign valid_o = v2_q;
   end else begin : g_lat1
      assign data_o  = word1;
      assign valid_o = v1_q;
   end

endmodule

// File: rtl/mem_mp.sv
// Multi-read-port memory with byte-enabled write, self-clearing after reset and
// sticky out-of-range flag. Same-cycle forwarding is selected by MEM_FWD_EN.
module mem_mp
   import mem_mp_pkg::*;
#(
   parameter int DATA_W   = 16,
   parameter int MEM_SIZE = 1000,
   parameter int NUM_RD   = 2,
   parameter int RD_LAT   = 1
) (
   input  logic    clk,
   input  logic    rst,
   mem_mp_if.slave bus
);
   localparam int ADDR_W = calc_addr_w(MEM_SIZE);
   localparam int BE_W   = calc_be_w(DATA_W);

   if (RD_LAT != 1 && RD_LAT != 2) begin : g_bad_lat
      $error("mem_mp: RD_LAT must be 1 or 2");
   end
   if (NUM_RD < 1 || NUM_RD > MAX_RD_PORTS) begin : g_bad_rd
      $error("mem_mp: NUM_RD out of range");
   end
   if (DATA_W % 8 != 0) begin : g_bad_dw
      $error("mem_mp: DATA_W must be a multiple of 8");
   end

   mem_state_t        state_q, state_d;
   logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
   logic [DATA_W-1:0] mem_q [MEM_SIZE];

   logic              accept;
   logic              clearing;
   logic              wr_in_range;
   logic              wr_en;
   logic              we_en;
   logic [ADDR_W-1:0] we_addr;
   logic [DATA_W-1:0] we_data;
   logic [BE_W-1:0]   we_be;
   logic [NUM_RD-1:0] rd_oor;
   logic              err_q;

   assign clearing    = (state_q == CLEAR);
   assign accept      = (state_q == READY) && rst;
   assign wr_in_range = ({1'b0, bus.addr_w} < (ADDR_W+1)'(MEM_SIZE));
   assign wr_en       = accept && bus.write && wr_in_range;

   // Clear and user writes share the single array write port
   assign we_en   = (clearing && rst) || wr_en;
   assign we_addr = clearing ? clr_addr_q : bus.addr_w;
   assign we_data = clearing ? '0 : bus.data_in;
   assign we_be   = clearing ? {BE_W{1'b1}} : bus.be_w;

   always_ff @(posedge clk) begin
      if (we_en) begin
         for (int k = 0; k < BE_W; k++) begin
            if (we_be[k]) begin
               mem_q[we_addr][8*k +: 8] <= we_data[8*k +: 8];
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= CLEAR;
         clr_addr_q <= '0;
      end else begin
         state_q    <= state_d;
         clr_addr_q <= clr_addr_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      clr_addr_d = clr_addr_q;
      case (state_q)
         CLEAR: begin
            clr_addr_d = clr_addr_q + 1'b1;
            if (clr_addr_q == ADDR_W'(MEM_SIZE - 1)) begin
               state_d    = READY;
               clr_addr_d = '0;
            end
         end
         READY: begin
            state_d = READY;
         end
         default: begin
            state_d = CLEAR;
         end
      endcase
   end

   assign bus.busy = clearing;

   for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
      logic              rd_en;
      logic [ADDR_W-1:0] rd_addr;
      logic [DATA_W-1:0] raw_q;
      logic [DATA_W-1:0] port_data;
      logic              port_valid;

      always_ff @(posedge clk) begin
         if (rd_en) begin
            raw_q <= mem_q[rd_addr];
         end
      end

      mem_mp_rd_pipe #(
         .DATA_W   (DATA_W),
         .MEM_SIZE (MEM_SIZE),
         .RD_LAT   (RD_LAT)
      ) u_pipe (
         .clk       (clk),
         .rst       (rst),
         .accept_i  (accept),
         .read_i    (bus.read[gi]),
         .addr_i    (bus.addr_r[gi*ADDR_W +: ADDR_W]),
         .wr_en_i   (wr_en),
         .wr_addr_i (bus.addr_w),
         .wr_data_i (bus.data_in),
         .wr_be_i   (bus.be_w),
         .raw_i     (raw_q),
         .rd_en_o   (rd_en),
         .rd_addr_o (rd_addr),
         .oor_o     (rd_oor[gi]),
         .data_o    (port_data),
         .valid_o   (port_valid)
      );

      assign bus.data_out[gi*DATA_W +: DATA_W] = port_data;
      assign bus.rd_valid[gi]                  = port_valid;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         err_q <= 1'b0;
      end else if (accept && ((bus.write && !wr_in_range) || (|rd_oor))) begin
         err_q <= 1'b1;
      end
   end

   assign bus.err_addr = err_q;

endmodule

// File: tb/tb_mem_mp.sv
// Directed bench for mem_mp: RD_LAT=1 and RD_LAT=2 instances share one stimulus stream.
module tb_mem_mp;
   localparam int DATA_W   = 16;
   localparam int MEM_SIZE = 1000;
   localparam int NUM_RD   = 2;
`ifdef MEM_FWD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   mem_mp_if #(.DATA_W(DATA_W), .MEM_SIZE(MEM_SIZE), .NUM_RD(NUM_RD)) bus1 ();
   mem_mp_if #(.DATA_W(DATA_W), .MEM_SIZE(MEM_SIZE), .NUM_RD(NUM_RD)) bus2 ();

   mem_mp #(.DATA_W(DATA_W), .MEM_SIZE(MEM_SIZE), .NUM_RD(NUM_RD), .RD_LAT(1)) u_dut1 (
      .clk (clk),
      .rst (rst),
      .bus (bus1.slave)
   );

   mem_mp #(.DATA_W(DATA_W), .MEM_SIZE(MEM_SIZE), .NUM_RD(NUM_RD), .RD_LAT(2)) u_dut2 (
      .clk (clk),
      .rst (rst),
      .bus (bus2.slave)
   );

   assign bus2.write   = bus1.write;
   assign bus2.addr_w  = bus1.addr_w;
   assign bus2.data_in = bus1.data_in;
   assign bus2.be_w    = bus1.be_w;
   assign bus2.read    = bus1.read;
   assign bus2.addr_r  = bus1.addr_r;

   int          n_chk  = 0;
   int          n_fail = 0;
   logic [15:0] model [MEM_SIZE];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_write(input logic [9:0] a, input logic [15:0] d, input logic [1:0] be);
      bus1.write   = 1'b1;
      bus1.addr_w  = a;
      bus1.data_in = d;
      bus1.be_w    = be;
      tick();
      bus1.write = 1'b0;
      $display("write addr=%0d data=%h be=%b", a, d, be);
   endtask

   task automatic do_read(input logic [9:0] a0, input logic [9:0] a1,
                          input logic [15:0] e0, input logic [15:0] e1);
      bus1.read   = 2'b11;
      bus1.addr_r = {a1, a0};
      tick();
      bus1.read = 2'b00;
      chk("rd1_valid", 32'(bus1.rd_valid), 32'h3);
      chk("rd1_data",  bus1.data_out, {e1, e0});
      chk("rd2_early", 32'(bus2.rd_valid), 32'h0);
      tick();
      chk("rd2_valid", 32'(bus2.rd_valid), 32'h3);
      chk("rd2_data",  bus2.data_out, {e1, e0});
      chk("rd1_pulse", 32'(bus1.rd_valid), 32'h0);
      chk("rd1_hold",  bus1.data_out, {e1, e0});
      $display("read p0 addr=%0d p1 addr=%0d exp=%h/%h", a0, a1, e0, e1);
   endtask

   // Port 0 ascending, port 1 descending, one request per cycle
   task automatic stream();
      for (int i = 0; i <= MEM_SIZE; i++) begin
         if (i < MEM_SIZE) begin
            bus1.read   = 2'b11;
            bus1.addr_r = {10'(MEM_SIZE - 1 - i), 10'(i)};
         end else begin
            bus1.read = 2'b00;
         end
         tick();
         if (i < MEM_SIZE) begin
            chk("s1_valid", 32'(bus1.rd_valid), 32'h3);
            chk("s1_data",  bus1.data_out, {model[MEM_SIZE - 1 - i], model[i]});
         end
         if (i > 0) begin
            chk("s2_valid", 32'(bus2.rd_valid), 32'h3);
            chk("s2_data",  bus2.data_out, {model[MEM_SIZE - i], model[i - 1]});
         end
      end
      tick();
      chk("s1_idle", 32'(bus1.rd_valid), 32'h0);
      chk("s2_idle", 32'(bus2.rd_valid), 32'h0);
      $display("stream read of %0d addresses on both ports done", MEM_SIZE);
   endtask

   task automatic wait_clear(output int cnt, output bit saw_valid);
      cnt       = 0;
      saw_valid = 1'b0;
      while (bus1.busy === 1'b1 && cnt < 2 * MEM_SIZE) begin
         tick();
         cnt++;
         if (bus1.rd_valid != 2'b00 || bus2.rd_valid != 2'b00) saw_valid = 1'b1;
      end
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int          cnt;
      bit          saw;
      int unsigned seed_init;
      logic [15:0] m8;
      logic [15:0] exp7;
      logic [15:0] exp8;

      seed_init    = $urandom(32'd12345);
      rst          = 1'b0;
      bus1.write   = 1'b0;
      bus1.addr_w  = '0;
      bus1.data_in = '0;
      bus1.be_w    = '0;
      bus1.read    = '0;
      bus1.addr_r  = '0;
      repeat (3) tick();

      chk("rst_busy1",  32'(bus1.busy), 32'h1);
      chk("rst_busy2",  32'(bus2.busy), 32'h1);
      chk("rst_valid1", 32'(bus1.rd_valid), 32'h0);
      chk("rst_valid2", 32'(bus2.rd_valid), 32'h0);
      chk("rst_data1",  bus1.data_out, 32'h0);
      chk("rst_data2",  bus2.data_out, 32'h0);
      chk("rst_err1",   32'(bus1.err_addr), 32'h0);

      // Requests held during the whole clear must all be ignored
      bus1.read    = 2'b11;
      bus1.addr_r  = {10'd1023, 10'd0};
      bus1.write   = 1'b1;
      bus1.addr_w  = 10'd3;
      bus1.data_in = 16'hFFFF;
      bus1.be_w    = 2'b11;
      rst          = 1'b1;
      wait_clear(cnt, saw);
      bus1.read  = 2'b00;
      bus1.write = 1'b0;
      chk("clear_cycles",   32'(cnt), 32'd1000);
      chk("clear_busy2",    32'(bus2.busy), 32'h0);
      chk("clear_no_valid", 32'(saw), 32'h0);
      chk("clear_err",      32'(bus1.err_addr), 32'h0);
      $display("clear finished after %0d cycles", cnt);

      for (int i = 0; i < MEM_SIZE; i++) model[i] = 16'h0000;
      do_read(10'd0, 10'd999, 16'h0000, 16'h0000);
      do_read(10'd3, 10'd3,   16'h0000, 16'h0000);

      for (int i = 0; i < MEM_SIZE; i++) begin
         model[i] = 16'($urandom);
         do_write(10'(i), model[i], 2'b11);
      end
      stream();

      do_write(10'd5, 16'hABCD, 2'b11);
      do_write(10'd5, 16'h1234, 2'b01);
      model[5] = 16'hAB34;
      do_read(10'd5, 10'd5, 16'hAB34, 16'hAB34);
      do_write(10'd6, 16'h5566, 2'b00);
      do_read(10'd6, 10'd5, model[6], 16'hAB34);

      chk("oor_err_pre", 32'(bus1.err_addr), 32'h0);
      do_write(10'd1000, 16'hFFFF, 2'b11);
      chk("oor_err_w1", 32'(bus1.err_addr), 32'h1);
      chk("oor_err_w2", 32'(bus2.err_addr), 32'h1);
      do_read(10'd1023, 10'd999, 16'h0000, model[999]);
      repeat (3) tick();
      chk("oor_sticky1", 32'(bus1.err_addr), 32'h1);
      chk("oor_sticky2", 32'(bus2.err_addr), 32'h1);

      do_write(10'd7, 16'h0001, 2'b11);
      model[7]     = 16'h0001;
      exp7         = FWD ? 16'h00FF : 16'h0001;
      bus1.write   = 1'b1;
      bus1.addr_w  = 10'd7;
      bus1.data_in = 16'h00FF;
      bus1.be_w    = 2'b11;
      bus1.read    = 2'b11;
      bus1.addr_r  = {10'd6, 10'd7};
      tick();
      bus1.write = 1'b0;
      bus1.read  = 2'b00;
      chk("col1_data", bus1.data_out, {model[6], exp7});
      tick();
      chk("col2_data", bus2.data_out, {model[6], exp7});
      $display("collision addr=7 exp=%h", exp7);
      model[7] = 16'h00FF;
      do_read(10'd7, 10'd7, 16'h00FF, 16'h00FF);

      m8           = model[8];
      exp8         = FWD ? {8'hAA, m8[7:0]} : m8;
      bus1.write   = 1'b1;
      bus1.addr_w  = 10'd8;
      bus1.data_in = 16'hAA55;
      bus1.be_w    = 2'b10;
      bus1.read    = 2'b11;
      bus1.addr_r  = {10'd8, 10'd8};
      tick();
      bus1.write = 1'b0;
      bus1.read  = 2'b00;
      chk("colp1_data", bus1.data_out, {exp8, exp8});
      tick();
      chk("colp2_data", bus2.data_out, {exp8, exp8});
      $display("partial collision addr=8 exp=%h", exp8);
      model[8] = {8'hAA, m8[7:0]};
      do_read(10'd8, 10'd9, model[8], model[9]);

      // Reset while the RD_LAT=2 read is still in flight
      bus1.read   = 2'b11;
      bus1.addr_r = {10'd1, 10'd0};
      tick();
      chk("inflight_rd1", 32'(bus1.rd_valid), 32'h3);
      rst       = 1'b0;
      bus1.read = 2'b00;
      tick();
      chk("flush_rd1",  32'(bus1.rd_valid), 32'h0);
      chk("flush_rd2",  32'(bus2.rd_valid), 32'h0);
      chk("flush_data", bus2.data_out, 32'h0);
      chk("flush_busy", 32'(bus2.busy), 32'h1);
      chk("flush_err",  32'(bus1.err_addr), 32'h0);
      rst = 1'b1;
      repeat (500) tick();
      chk("mid_busy", 32'(bus1.busy), 32'h1);
      rst       = 1'b0;
      bus1.read = 2'b11;
      tick();
      rst = 1'b1;
      wait_clear(cnt, saw);
      bus1.read = 2'b00;
      chk("reclear_cycles",   32'(cnt), 32'd1000);
      chk("reclear_no_valid", 32'(saw), 32'h0);
      $display("re-clear finished after %0d cycles", cnt);

      for (int i = 0; i < MEM_SIZE; i++) model[i] = 16'h0000;
      stream();
      chk("post_err", 32'(bus1.err_addr), 32'h0);
      do_read(10'd1023, 10'd5, 16'h0000, 16'h0000);
      chk("rd_oor_err1", 32'(bus1.err_addr), 32'h1);
      chk("rd_oor_err2", 32'(bus2.err_addr), 32'h1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_mp.md
Name: mem_mp

Overview:
- Parametrised successor of the single-read-port `mem` block: one write port with byte enables and NUM_RD independent read ports.
- Read latency is selectable (1 or 2 cycles); each port has a per-port valid strobe.
- A self-clearing FSM zeroes the array after every reset. Out-of-range accesses are detected and flagged.
- Used as register-file / scratchpad storage in datapaths needing parallel reads.

Parameters:
- DATA_W, 16, word width in bits; must be a multiple of 8.
- MEM_SIZE, 1000, number of words; need not be a power of 2.
- NUM_RD, 2, number of read ports (1..4).
- RD_LAT, 1, read latency in cycles; legal values 1 or 2; elaboration error otherwise.
- ADDR_W, $clog2(MEM_SIZE), derived localparam, not overridable.
- BE_W, DATA_W/8, derived localparam.

Ports:
- clk  in  1  clock, all logic on posedge.
- rst  in  1  synchronous, active-low reset.
- write  in  1  write request.
- addr_w  in  ADDR_W  write address.
- data_in  in  DATA_W  write data.
- be_w  in  BE_W  byte enables; bit k covers data_in[8k+7:8k].
- read  in  NUM_RD  per-port read request.
- addr_r  in  NUM_RD*ADDR_W  packed read addresses; port p at [p*ADDR_W +: ADDR_W].
- data_out  out  NUM_RD*DATA_W  packed read data, same packing.
- rd_valid  out  NUM_RD  per-port data valid strobe.
- busy  out  1  high while clearing; all requests ignored.
- err_addr  out  1  sticky out-of-range flag.

Behaviour:
- Reset (rst==0 at posedge):
  - FSM -> CLEAR, clr_addr=0, busy=1.
  - data_out=0, rd_valid=0, err_addr=0.
  - Read pipeline flushed; in-flight reads never produce rd_valid.
- FSM CLEAR:
  - Each cycle writes 0 to mem[clr_addr] and increments clr_addr.
  - After writing MEM_SIZE-1 -> READY.
  - busy is high for exactly MEM_SIZE cycles after rst deasserts.
  - write/read ignored; err_addr not updated.
- FSM READY:
  - Holds until reset.
  - Reset mid-CLEAR or mid-READY restarts CLEAR from address 0.
- Write (READY, write==1, addr_w<MEM_SIZE):
  - For each k with be_w[k]==1, byte k of mem[addr_w] <= byte k of data_in.
  - Other bytes are unchanged. be_w==0 is a no-op.
- Read port p (READY, read[p]==1):
  - Address sampled at posedge T.
  - data_out[p] and rd_valid[p]=1 presented after posedge T+RD_LAT-1 (RD_LAT=1: visible the cycle after the request; RD_LAT=2: one extra register stage).
  - rd_valid[p] is a single-cycle pulse per request; back-to-back requests give back-to-back valid.
  - With read[p]==0, rd_valid[p]=0 and data_out[p] holds its last value.
- Multiple ports may read the same or different addresses in the same cycle; no conflicts.
- Out-of-range address (>= MEM_SIZE, e.g. 1000..1023 at defaults):
  - Write: dropped.
  - Read: returns 0 with rd_valid asserted normally.
  - Either sets err_addr=1; it stays set until reset.
- Read-during-write, same address, same cycle: the default returns old (pre-write) data; see MEM_FWD_EN.

Optional Feature:
- Macro: MEM_FWD_EN.
- Defined:
  - Read-during-write to the same in-range address returns the merged new word: enabled bytes from data_in, other bytes from the stored word.
  - Applies to all ports and to both RD_LAT values.
  - For RD_LAT=2, a write landing between request and output is not forwarded; only same-cycle collisions are.
- Undefined: old data returned; no forwarding logic is synthesised.

Decomposition:
- Package mem_mp_pkg:
  - typedef enum logic {CLEAR, READY} mem_state_t.
  - Function computing ADDR_W/BE_W.
  - Constant MAX_RD_PORTS=4.
- Sub-module mem_mp_rd_pipe: one instance per read port.
  - Handles address range check, optional forwarding mux and RD_LAT delay of data/valid.
  - Top level holds the array, write logic and clear FSM.

Test Plan:
- Reset then idle: busy high for exactly 1000 cycles; afterwards read ports 0/1 at addresses 0 and 999 -> data_out 0, rd_valid 1 after RD_LAT cycles.
- Fill with seeded random 16-bit words using be_w=2'b11 over 0..999; read all addresses on port 0 ascending and port 1 descending simultaneously, RD_LAT=1 and RD_LAT=2 -> every word matches the model, valid pulses aligned.
- Byte enables: write 16'hABCD at addr 5 with be_w=11, then 16'h1234 with be_w=01 -> read returns 16'hAB34.
- Out of range: write 16'hFFFF to addr 1000, read addr 1023 -> data_out 0, rd_valid 1, err_addr 1 and sticky; addr 999 unchanged.
- Collision: mem[7]=16'h0001; same cycle write 16'h00FF be=11 and read 7 -> 16'h0001 without MEM_FWD_EN, 16'h00FF with it.
- Reset at clear cycle 500 and with reads in flight -> no rd_valid emitted; busy high for a fresh 1000 cycles; all words read 0 afterwards.
